// File: rtl/can_bit_destuff_pkg.sv
// Shared constants, FSM state type and the CRC-15 step function for the CAN
// receive destuffer (the CRC step is reused by the transmit path).
package can_bit_destuff_pkg;

  localparam int unsigned DEF_STUFF_LEN = 5;
  localparam logic [14:0] DEF_CRC_POLY  = 15'h4599;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    RUN          = 2'd1,
    EXPECT_STUFF = 2'd2,
    ERROR        = 2'd3
  } destuff_state_t;

  function automatic logic [14:0] crc15_step(input logic [14:0] crc,
                                             input logic        bit_in,
                                             input logic [14:0] poly);
    logic nxt;
    nxt = bit_in ^ crc[14];
    return {crc[13:0], 1'b0} ^ (nxt ? poly : 15'd0);
  endfunction

endpackage

// File: rtl/can_crc15.sv
// CAN CRC-15 accumulator: one bit per enabled cycle, synchronous clear wins
// over enable.
module can_crc15
  import can_bit_destuff_pkg::*;
#(
  parameter logic [14:0] POLY = DEF_CRC_POLY
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [14:0] crc
);

  logic [14:0] crc_q;
  logic [14:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 15'd0;
    end else if (en) begin
      crc_d = crc15_step(crc_q, bit_in, POLY);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= 15'd0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/can_bit_destuff.sv
// CAN receive bit destuffer: strips stuff bits from the sampled bus stream,
// flags stuff violations and accumulates CRC-15 over the destuffed bits.
module can_bit_destuff
  import can_bit_destuff_pkg::*;
#(
  parameter int unsigned STUFF_LEN = DEF_STUFF_LEN,
  parameter logic [14:0] CRC_POLY  = DEF_CRC_POLY
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           sample,
  input  logic           rx_bit,
  input  logic           destuff_en,
  input  logic           crc_en,
  output logic           data_bit,
  output logic           data_valid,
  output logic           stuff_drop,
  output logic           stuff_error,
  output logic [14:0]    crc_reg,
  output logic           crc_zero,
  output destuff_state_t state_dbg
);

  // Strobe protocol: there is no back-pressure. rx_bit is taken on every
  // cycle with sample high; each taken bit yields at most one registered
  // one-cycle pulse (data_valid or stuff_drop, never both) on the next cycle.

  localparam logic [2:0] STUFF_LEN_W = 3'(STUFF_LEN);

  destuff_state_t state_q, state_d;
  logic           last_bit_q, last_bit_d;
  logic [2:0]     run_len_q, run_len_d;
  logic           data_bit_q, data_bit_d;
  logic           data_valid_q, data_valid_d;
  logic           stuff_drop_q, stuff_drop_d;
  logic           stuff_error_q, stuff_error_d;
  logic           accept_data;

  always_comb begin
    state_d       = state_q;
    last_bit_d    = last_bit_q;
    run_len_d     = run_len_q;
    data_bit_d    = data_bit_q;
    data_valid_d  = 1'b0;
    stuff_drop_d  = 1'b0;
    stuff_error_d = stuff_error_q;
    accept_data   = 1'b0;

    if (!destuff_en) begin
      // Enable low dominates, including a sample in the same cycle.
      state_d       = IDLE;
      run_len_d     = 3'd0;
      stuff_error_d = 1'b0;
    end else if (sample) begin
      unique case (state_q)
        IDLE: begin
          accept_data = 1'b1;
          last_bit_d  = rx_bit;
          run_len_d   = 3'd1;
          state_d     = (STUFF_LEN_W == 3'd1) ? EXPECT_STUFF : RUN;
        end
        RUN: begin
          accept_data = 1'b1;
          last_bit_d  = rx_bit;
          if (rx_bit == last_bit_q) begin
            run_len_d = (run_len_q >= STUFF_LEN_W) ? STUFF_LEN_W
                                                   : run_len_q + 3'd1;
          end else begin
            run_len_d = 3'd1;
          end
          if (run_len_d == STUFF_LEN_W) begin
            state_d = EXPECT_STUFF;
          end
        end
        EXPECT_STUFF: begin
          if (rx_bit != last_bit_q) begin
            // The stuff bit itself opens the next run.
            stuff_drop_d = 1'b1;
            last_bit_d   = rx_bit;
            run_len_d    = 3'd1;
            state_d      = (STUFF_LEN_W == 3'd1) ? EXPECT_STUFF : RUN;
          end else begin
            stuff_error_d = 1'b1;
            state_d       = ERROR;
          end
        end
        ERROR: begin
          state_d = ERROR;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (accept_data) begin
      data_valid_d = 1'b1;
      data_bit_d   = rx_bit;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_bit_q    <= 1'b1;
      run_len_q     <= 3'd0;
      data_bit_q    <= 1'b0;
      data_valid_q  <= 1'b0;
      stuff_drop_q  <= 1'b0;
      stuff_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_bit_q    <= last_bit_d;
      run_len_q     <= run_len_d;
      data_bit_q    <= data_bit_d;
      data_valid_q  <= data_valid_d;
      stuff_drop_q  <= stuff_drop_d;
      stuff_error_q <= stuff_error_d;
    end
  end

  // CRC updates on the same edge that raises data_valid, so crc_reg already
  // includes the bit while its pulse is visible.
  can_crc15 #(
    .POLY (CRC_POLY)
  ) u_crc (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (~destuff_en),
    .en      (accept_data & crc_en),
    .bit_in  (rx_bit),
    .crc     (crc_reg)
  );

  assign data_bit    = data_bit_q;
  assign data_valid  = data_valid_q;
  assign stuff_drop  = stuff_drop_q;
  assign stuff_error = stuff_error_q;
  assign crc_zero    = (crc_reg == 15'd0);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_can_bit_destuff.sv
// Bench for can_bit_destuff: directed scenarios plus random bit streams
// checked against a window-based stuffing model and a from-scratch CRC.
module tb_can_bit_destuff;
  import can_bit_destuff_pkg::*;

  localparam int          SL   = 5;
  localparam logic [14:0] POLY = 15'h4599;

  logic           clock;
  logic           reset_n;
  logic           sample;
  logic           rx_bit;
  logic           destuff_en;
  logic           crc_en;
  logic           data_bit;
  logic           data_valid;
  logic           stuff_drop;
  logic           stuff_error;
  logic [14:0]    crc_reg;
  logic           crc_zero;
  destuff_state_t state_dbg;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_drop   = 0;

  // Reference model: raw bits since enable, CRC'd data bits, sticky error.
  logic hist[$];
  logic crc_bits[$];
  logic m_err;
  logic m_data_bit;

  can_bit_destuff dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sample      (sample),
    .rx_bit      (rx_bit),
    .destuff_en  (destuff_en),
    .crc_en      (crc_en),
    .data_bit    (data_bit),
    .data_valid  (data_valid),
    .stuff_drop  (stuff_drop),
    .stuff_error (stuff_error),
    .crc_reg     (crc_reg),
    .crc_zero    (crc_zero),
    .state_dbg   (state_dbg)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [14:0] model_crc();
    logic [14:0] c;
    logic        n;
    c = 15'd0;
    foreach (crc_bits[i]) begin
      n = crc_bits[i] ^ c[14];
      c = {c[13:0], 1'b0} ^ (n ? POLY : 15'd0);
    end
    return c;
  endfunction

  // A stuff bit is due whenever the last SL raw bits of this frame are equal.
  function automatic logic stuff_due();
    if (hist.size() < SL) return 1'b0;
    for (int i = 1; i <= SL; i++) begin
      if (hist[hist.size() - i] != hist[hist.size() - 1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_clear();
    hist.delete();
    crc_bits.delete();
    m_err = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, then check all outputs.
  task automatic step(input logic s, input logic b, input logic en,
                      input logic ce);
    logic        ev, ed;
    logic [14:0] ecrc;
    sample = s; rx_bit = b; destuff_en = en; crc_en = ce;
    ev = 1'b0; ed = 1'b0;
    if (!en) begin
      model_clear();
    end else if (s && !m_err) begin
      if (stuff_due()) begin
        if (b != hist[hist.size() - 1]) ed = 1'b1;
        else m_err = 1'b1;
      end else begin
        ev = 1'b1;
        m_data_bit = b;
        if (ce) crc_bits.push_back(b);
      end
      if (!m_err) hist.push_back(b);
    end
    ecrc = model_crc();
    @(posedge clock); #1;
    sample = 1'b0;
    if (data_valid) n_valid++;
    if (stuff_drop) n_drop++;
    checks++;
    if (data_valid !== ev) begin
      failures++;
      $display("FAIL data_valid got=%b exp=%b t=%0t", data_valid, ev, $time);
    end
    checks++;
    if (stuff_drop !== ed) begin
      failures++;
      $display("FAIL stuff_drop got=%b exp=%b t=%0t", stuff_drop, ed, $time);
    end
    checks++;
    if (data_bit !== m_data_bit) begin
      failures++;
      $display("FAIL data_bit got=%b exp=%b t=%0t", data_bit, m_data_bit, $time);
    end
    checks++;
    if (stuff_error !== m_err) begin
      failures++;
      $display("FAIL stuff_error got=%b exp=%b t=%0t", stuff_error, m_err, $time);
    end
    checks++;
    if (crc_reg !== ecrc) begin
      failures++;
      $display("FAIL crc_reg got=%h exp=%h t=%0t", crc_reg, ecrc, $time);
    end
    checks++;
    if (crc_zero !== (ecrc == 15'd0)) begin
      failures++;
      $display("FAIL crc_zero got=%b exp=%b t=%0t", crc_zero, (ecrc == 15'd0), $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({data_bit, data_valid, stuff_drop, stuff_error, crc_zero} !== 5'b00001
        || crc_reg !== 15'd0) begin
      failures++;
      $display("FAIL %s outputs got=%b%b%b%b%b crc=%h exp=00001 crc=0000",
               tag, data_bit, data_valid, stuff_drop, stuff_error, crc_zero, crc_reg);
    end
    checks++;
    if (state_dbg !== IDLE) begin
      failures++;
      $display("FAIL %s state got=%0d exp=%0d", tag, state_dbg, IDLE);
    end
  endtask

  task automatic test_reset();
    check_reset_outputs("reset");
  endtask

  task automatic test_basic_destuff();
    logic seq[7] = '{0, 0, 0, 0, 0, 1, 1};
    step(0, 0, 0, 0);
    n_valid = 0; n_drop = 0;
    for (int i = 0; i < 7; i++) step(1, seq[i], 1, 1);
    checks++;
    if (n_valid != 6 || n_drop != 1) begin
      failures++;
      $display("FAIL basic_counts valid=%0d drop=%0d exp valid=6 drop=1", n_valid, n_drop);
    end
  endtask

  task automatic test_new_run();
    logic seq[11] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    step(0, 0, 0, 0);
    n_valid = 0; n_drop = 0;
    for (int i = 0; i < 11; i++) step(1, seq[i], 1, 0);
    checks++;
    if (n_valid != 9 || n_drop != 2 || stuff_error !== 1'b0) begin
      failures++;
      $display("FAIL new_run valid=%0d drop=%0d err=%b exp 9 2 0", n_valid, n_drop, stuff_error);
    end
  endtask

  task automatic test_stuff_error();
    step(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 1);
    checks++;
    if (stuff_error !== 1'b1) begin
      failures++;
      $display("FAIL stuff_err_set got=%b exp=1", stuff_error);
    end
    n_valid = 0; n_drop = 0;
    for (int i = 0; i < 4; i++) step(1, i[0], 1, 1);
    checks++;
    if (n_valid != 0 || n_drop != 0) begin
      failures++;
      $display("FAIL err_quiet valid=%0d drop=%0d exp 0 0", n_valid, n_drop);
    end
    step(0, 0, 0, 0);
    checks++;
    if (stuff_error !== 1'b0) begin
      failures++;
      $display("FAIL stuff_err_clear got=%b exp=0", stuff_error);
    end
  endtask

  task automatic test_crc();
    step(0, 0, 0, 0);
    step(1, 1, 1, 1);
    checks++;
    if (crc_reg !== 15'h4599) begin
      failures++;
      $display("FAIL crc_first got=%h exp=4599", crc_reg);
    end
    step(1, 0, 1, 1);
    checks++;
    if (crc_reg !== 15'h4EAB) begin
      failures++;
      $display("FAIL crc_second got=%h exp=4eab", crc_reg);
    end
    step(0, 0, 0, 0);
    checks++;
    if (crc_reg !== 15'd0 || crc_zero !== 1'b1) begin
      failures++;
      $display("FAIL crc_clear got=%h zero=%b exp=0000 zero=1", crc_reg, crc_zero);
    end
  endtask

  task automatic test_mid_reset();
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1);
    destuff_en = 1'b1;
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    model_clear();
    m_data_bit = 1'b0;
    @(posedge clock); #2 reset_n = 1'b1;
    @(posedge clock); #1;
    n_drop = 0;
    for (int i = 0; i < 4; i++) step(1, 1, 1, 1);
    checks++;
    if (n_drop != 0) begin
      failures++;
      $display("FAIL reset_run_clear drops=%0d exp=0", n_drop);
    end
  endtask

  task automatic test_enable_drop();
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1);
    step(1, 1, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 1);
    step(1, 0, 0, 1);
  endtask

  task automatic test_random();
    logic prev;
    int   len;
    for (int f = 0; f < 40; f++) begin
      step(0, 0, 0, 0);
      prev = 1'($urandom_range(0, 1));
      len  = $urandom_range(10, 60);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 9) >= 7) prev = ~prev;
        step(($urandom_range(0, 3) != 0), prev,
             ($urandom_range(0, 99) != 0), ($urandom_range(0, 7) != 0));
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; sample = 1'b0; rx_bit = 1'b0;
    destuff_en = 1'b0; crc_en = 1'b0;
    m_err = 1'b0; m_data_bit = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    test_reset();
    test_basic_destuff();
    test_new_run();
    test_stuff_error();
    test_crc();
    test_mid_reset();
    test_enable_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
